// File: rtl/vga_sync_monitor.sv
// rtl/vga_sync_monitor.sv - VGA sync timing checker with position recovery and lock detection
module vga_sync_monitor #(
    parameter int H_TOTAL     = 768,
    parameter int V_TOTAL     = 512,
    parameter int LOCK_FRAMES = 2,
    parameter int TIMEOUT     = 1536
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vga_h_sync,
    input  logic        vga_v_sync,
    output logic [9:0]  x_pos,
    output logic [9:0]  y_pos,
    output logic [10:0] line_len,
    output logic [9:0]  frame_lines,
    output logic        line_start,
    output logic        frame_start,
    output logic        locked,
    output logic        timing_err
);

    typedef enum logic [1:0] {
        SEARCH,
        ACQUIRE,
        LOCKED
    } state_t;

    localparam logic [10:0] H_LEN  = 11'(H_TOTAL);
    localparam logic [10:0] TO_LEN = 11'(TIMEOUT);
    localparam logic [9:0]  V_LEN  = 10'(V_TOTAL);
    localparam logic [7:0]  LOCK_N = 8'(LOCK_FRAMES);

    state_t      state;
    logic        hs_q;
    logic        vs_q;
    logic [10:0] lc;
    logic [9:0]  fc;
    logic        meas_valid;
    logic        line_bad;
    logic [7:0]  good_cnt;

    logic        h_edge;
    logic        v_edge;
    logic [10:0] lc_inc;
    logic [9:0]  fc_inc;
    logic [9:0]  y_inc;
    logic        cur_line_bad;
    logic        frame_good;
    logic        timeout;

    // Edge detection, saturating increments and the per-cycle line/frame verdicts
    always_comb begin
        h_edge       = hs_q & ~vga_h_sync;
        v_edge       = vs_q & ~vga_v_sync;
        lc_inc       = (lc == 11'h7FF) ? lc : lc + 11'd1;
        fc_inc       = (fc == 10'h3FF) ? fc : fc + 10'd1;
        y_inc        = (y_pos == 10'h3FF) ? y_pos : y_pos + 10'd1;
        // lc_inc is the length of the line ending at this edge
        cur_line_bad = h_edge & meas_valid & (lc_inc != H_LEN);
        // The line closed by a coincident h edge still belongs to the old frame
        frame_good   = ~(line_bad | cur_line_bad) & (fc == V_LEN);
        // Fires once, on the cycle lc first reaches TIMEOUT
        timeout      = ~h_edge & (lc_inc == TO_LEN) & (lc != TO_LEN);
    end

    // Counters, measurements, registered outputs and the lock state machine
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= SEARCH;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            lc          <= '0;
            fc          <= '0;
            meas_valid  <= 1'b0;
            line_bad    <= 1'b0;
            good_cnt    <= '0;
            x_pos       <= '0;
            y_pos       <= '0;
            line_len    <= '0;
            frame_lines <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            timing_err  <= 1'b0;
        end else begin
            hs_q        <= vga_h_sync;
            vs_q        <= vga_v_sync;
            line_start  <= h_edge;
            frame_start <= v_edge;
            timing_err  <= 1'b0;

            if (h_edge) begin
                lc    <= '0;
                x_pos <= '0;
                if (meas_valid) begin
                    line_len <= lc_inc;
                end
                meas_valid <= 1'b1;
                if (cur_line_bad) begin
                    line_bad <= 1'b1;
                end
            end else begin
                lc    <= lc_inc;
                x_pos <= (lc_inc > 11'd1023) ? 10'h3FF : lc_inc[9:0];
            end

            if (v_edge) begin
                frame_lines <= fc;
                fc          <= h_edge ? 10'd1 : 10'd0;
                y_pos       <= '0;
                line_bad    <= 1'b0;
            end else if (h_edge) begin
                fc    <= fc_inc;
                y_pos <= y_inc;
            end

            if (timeout) begin
                state      <= SEARCH;
                meas_valid <= 1'b0;
                locked     <= 1'b0;
                if (state == LOCKED) begin
                    timing_err <= 1'b1;
                end
            end else begin
                case (state)
                    SEARCH: begin
                        if (v_edge) begin
                            state    <= ACQUIRE;
                            good_cnt <= '0;
                        end
                    end
                    ACQUIRE: begin
                        if (v_edge) begin
                            if (frame_good) begin
                                good_cnt <= good_cnt + 8'd1;
                                if (good_cnt + 8'd1 >= LOCK_N) begin
                                    state  <= LOCKED;
                                    locked <= 1'b1;
                                end
                            end else begin
                                good_cnt   <= '0;
                                timing_err <= 1'b1;
                            end
                        end
                    end
                    LOCKED: begin
                        if (cur_line_bad || (v_edge && !frame_good)) begin
                            state      <= ACQUIRE;
                            locked     <= 1'b0;
                            good_cnt   <= '0;
                            timing_err <= 1'b1;
                        end
                    end
                    default: begin
                        state  <= SEARCH;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/vga_sync_monitor.md
# vga_sync_monitor

Receive-side checker for the VGA timing produced by our sync generator. It samples the active-low horizontal and vertical sync lines in the `clk` domain and measures line length and lines per frame. From those it recovers pixel/line position counters and reports lock once the timing has matched the expected raster for consecutive frames. It sits beside the display path as a self-check, and as a bench monitor for game-logic blocks that need a position reference.

## Interface
Parameters:
- `H_TOTAL`, 768: expected clocks between successive horizontal-sync falling edges.
- `V_TOTAL`, 512: expected horizontal-sync falling edges between successive vertical-sync falling edges.
- `LOCK_FRAMES`, 2: consecutive good frames required to assert lock.
- `TIMEOUT`, 1536: clocks without a horizontal-sync falling edge before falling back to search.

Ports:
- `clk` in 1: single clock for the whole block.
- `reset` in 1: synchronous, active-high reset.
- `vga_h_sync` in 1: horizontal sync, active low, synchronous to `clk`.
- `vga_v_sync` in 1: vertical sync, active low, synchronous to `clk`.
- `x_pos` out 10: clocks since the last horizontal-sync falling edge; saturates at 1023.
- `y_pos` out 10: horizontal-sync falling edges since the last vertical-sync falling edge; saturates at 1023.
- `line_len` out 11: last completed line measurement; saturates at 2047.
- `frame_lines` out 10: last completed frame line count; saturates at 1023.
- `line_start` out 1: one-cycle pulse per horizontal-sync falling edge.
- `frame_start` out 1: one-cycle pulse per vertical-sync falling edge.
- `locked` out 1: timing verified.
- `timing_err` out 1: one-cycle pulse on a bad line or bad frame.

## Operation
- Edge detection:
  - Both sync inputs are registered once (`hs_q`, `vs_q`, reset value 1).
  - A falling edge is the cycle where `hs_q`=1 and input=0.
  - A vertical-sync edge is detected the same way.
- Line counter `lc` (11 bits, saturating):
  - On a horizontal-sync edge: `line_len` <= `lc`+1, then `lc` <= 0.
  - Otherwise `lc` increments.
  - `x_pos` mirrors `lc`, saturating at 1023.
- The first horizontal-sync edge after reset or after entering SEARCH only starts measuring. `line_len` is not updated and no check is made.
- Frame counter `fc` (10 bits, saturating):
  - Increments on each horizontal-sync edge; `y_pos` mirrors it.
  - On a vertical-sync edge: `frame_lines` <= `fc`, then `fc` <= 0.
  - If a horizontal-sync edge occurs in the same cycle, it counts toward the new frame: `fc` <= 1.
  - `x_pos` and `y_pos` then both read 0 on the next cycle.
- Line check: `line_bad` is set when a measured line ≠ `H_TOTAL`. It is cleared at each vertical-sync edge.
- Frame check: a frame is good when `line_bad`=0 and the frame line count = `V_TOTAL`.
- State machine:
  - SEARCH: reset state. On the first vertical-sync edge, go to ACQUIRE with `good_cnt`=0 and `line_bad`=0. Frame outputs are not checked.
  - ACQUIRE:
    - At each vertical-sync edge, a good frame increments `good_cnt`; a bad frame clears `good_cnt` and pulses `timing_err`.
    - When `good_cnt` reaches `LOCK_FRAMES`, go to LOCKED.
  - LOCKED: a bad line (at its horizontal-sync edge) or a bad frame (at its vertical-sync edge) pulses `timing_err` and moves to ACQUIRE with `good_cnt`=0.
  - Any state: `lc` reaching `TIMEOUT` without a horizontal-sync edge moves to SEARCH, clears the measurement-valid flag, and pulses `timing_err` only if the block was LOCKED.
- `locked` = 1 exactly while in LOCKED.

## Timing
- Reset values: all outputs 0; `hs_q`/`vs_q` 1; state SEARCH.
- Reset asserted mid-frame takes effect on the next edge of `clk` regardless of sync activity.
- Outputs are registered. `line_start`, `frame_start`, `line_len`, `frame_lines`, `x_pos`=0 and `y_pos` updates appear one cycle after the cycle in which the input is first sampled low (latency 2 from the input edge to the output change, counting the input register).
- `locked` rises in the same cycle as the `frame_start` of the frame that completes the `LOCK_FRAMES`-th good frame.
- `locked` falls, and `timing_err` pulses, in the same cycle as the offending `line_start` or `frame_start`.
- A horizontal-sync pulse width is not checked. Only falling edges matter; held-low inputs produce no further edges.

## Test plan
- Ideal raster (768 clk/line, 16-clk horizontal-sync low, vertical-sync low for one line every 512 lines) after reset:
  - `line_len`=768, `frame_lines`=512.
  - `locked` rises at the 3rd `frame_start` (first one enters ACQUIRE, then 2 good frames).
  - `timing_err` never pulses.
- While locked, shorten one line to 767 clocks:
  - `timing_err` pulses and `locked` drops at that `line_start`.
  - The next frame is still bad (767 recorded).
  - `locked` returns after 2 further good frames.
- While locked, stop horizontal-sync toggling:
  - `x_pos` saturates at 1023.
  - At `lc`=1536, state goes to SEARCH, `locked`=0, single `timing_err`.
- Vertical-sync and horizontal-sync falling edges in the same cycle: next cycle `x_pos`=0, `y_pos`=0, and a subsequent frame of 512 edges reports `frame_lines`=512.
- Frame of 511 lines while in ACQUIRE after one good frame: `good_cnt` clears, `timing_err` pulses, and lock requires 2 further good frames.
- Reset asserted mid-frame while LOCKED: next cycle all outputs 0 and state SEARCH; relock follows the first scenario.
